// File: rtl/bit_stream_feeder.sv
// bit_stream_feeder
//   Streams 1-bit words out of a Block RAM, one word per enable period.
//   A start pulse in IDLE begins a pass from address 0. Each word is
//   fetched (FETCH, one cycle of RAM latency), captured onto bit_o
//   (CAPTURE), and then held (HOLD) until the tick counter completes a
//   period. At that point a single-cycle one_second_enable is issued and
//   the next address is requested. The last word either wraps to address
//   0 (LOOP=1) or ends the pass with a done pulse (LOOP=0).
//
// Ports
//   clock_100Mhz      in   single clock, all logic on its rising edge
//   reset             in   synchronous, active-high
//   start             in   begin streaming from address 0 (IDLE only)
//   stop              in   abort streaming (any state)
//   mem_addr          out  registered Block RAM read address
//   mem_rdata         in   Block RAM data, valid one cycle after mem_addr
//   bit_o             out  current stream bit (named bit_o because bit is
//                          a reserved word)
//   one_second_enable out  single-cycle qualifier for bit_o
//   bit_index         out  address of the word currently on bit_o
//   busy              out  high in every state except IDLE
//   done              out  one-cycle pulse at the end of a pass (LOOP=0)
module bit_stream_feeder #(
  parameter int TICK_DIV = 100_000_000,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int LOOP     = 0
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdata,
  output logic              bit_o,
  output logic              one_second_enable,
  output logic [ADDR_W-1:0] bit_index,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              bit_q,   bit_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic              en_q,    en_d;
  logic              done_q,  done_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              busy_w;

  assign busy_w = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    // The period counter free-runs while busy; it is reloaded only on the
    // start edge and on each pulse edge, so pulse spacing is exact.
    cnt_d   = busy_w ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // RAM read latency: data for addr_q appears on the next cycle.
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        bit_d   = mem_rdata;
        idx_d   = addr_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          en_d  = 1'b1;
          cnt_d = '0;
          if (idx_q != ADDR_LAST) begin
            addr_d  = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else if (LOOP != 0) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            // done rises together with the final enable.
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything above. An enable already registered in
    // en_q still completes its single cycle because en_d is recomputed.
    if (stop && busy_w) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      bit_q   <= 1'b0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples the pre-edge value of the others.
      state_q <= state_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr          = addr_q;
  assign bit_o             = bit_q;
  assign one_second_enable = en_q;
  assign bit_index         = idx_q;
  assign busy              = busy_w;
  assign done              = done_q;

endmodule
